seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: operands and mode are presented.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have the ports op_a and op_b, input, WIDTH bits each: the multiplicand and multiplier, with index 0 as MSB.
REQ-007 The block SHALL have the port is_signed, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: the product is valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the product.
REQ-010 The block SHALL have the port product, output, 2*WIDTH bits, index 0 MSB: the product, in two's complement when is_signed was 1.
REQ-011 The block SHALL have the port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-012 The block SHALL be a sequential shift-add multiplier with three states: IDLE, BUSY and DONE.
REQ-013 The block SHALL drive in_ready = 1 only in IDLE.
REQ-014 An input transfer SHALL occur on an edge where in_valid && in_ready, and on that edge the block SHALL:
- capture op_a, op_b and is_signed;
- clear the accumulator;
- enter BUSY.
REQ-015 At capture with is_signed = 1, the block SHALL store the operand magnitudes as unsigned WIDTH-bit values (-2^(WIDTH-1) maps to 2^(WIDTH-1)) and record sign = MSB(op_a) XOR MSB(op_b).
REQ-016 On each edge in BUSY, the block SHALL add the 2*WIDTH-bit zero-extended multiplicand, shifted left by the iteration count, when the current multiplier LSB is 1, then shift the multiplier right by one.
REQ-017 After WIDTH BUSY iterations, the block SHALL enter DONE with out_valid = 1, which is WIDTH edges after the accepting edge.
REQ-018 On the final iteration, when sign = 1, the block SHALL negate the accumulator (two's complement, 2*WIDTH bits) so that product is correct on the first out_valid cycle.
REQ-019 In DONE, product and out_valid SHALL hold stable until out_valid && out_ready on an edge, and then the block SHALL return to IDLE.
REQ-020 In-flight operands SHALL be unaffected by input changes during BUSY or DONE, and in_valid in those states SHALL be ignored.
REQ-021 No new operand SHALL be accepted on the same edge as a product handoff; the minimum issue interval is WIDTH+2 cycles.
REQ-022 The product SHALL never overflow the 2*WIDTH-bit result: the unsigned maximum (2^WIDTH-1)^2 and the signed extreme (-2^(WIDTH-1))^2 are both representable.

Reset
REQ-023 While rst_n = 0 at a clock edge, the block SHALL enter IDLE and set in_ready = 1, out_valid = 0, busy = 0, product = 0, and clear the accumulator, counter and sign.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation with no out_valid pulse.
REQ-025 In the first cycle after rst_n rises, the block SHALL be able to accept operands.

Configuration
REQ-026 The macro SEQ_MULT_EARLY_TERM_EN SHALL control early termination.
REQ-027 With SEQ_MULT_EARLY_TERM_EN defined, the block SHALL enter DONE on the edge that processes the last 1 bit of the multiplier, with any final negation applied on that edge.
- A zero multiplier SHALL reach DONE 1 edge after accept, with product = 0.
- Latency SHALL be between 1 and WIDTH edges.
REQ-028 Without SEQ_MULT_EARLY_TERM_EN, latency SHALL be exactly WIDTH edges for all operands.

Verification
REQ-029 With WIDTH=8, unsigned, op_a=255 and op_b=255: product SHALL be 0xFE01, with out_valid exactly 8 edges after accept.
REQ-030 With WIDTH=8, signed, op_a=0x80 and op_b=0x80: product SHALL be 0x4000; with op_a=0xFF and op_b=0x7F: product SHALL be 0xFF81.
REQ-031 With out_ready held at 0 for 5 cycles in DONE: product and out_valid SHALL stay stable, in_valid SHALL be ignored, and the block SHALL return to IDLE the cycle after out_ready = 1.
REQ-032 With rst_n = 0 asserted 3 cycles into BUSY: all outputs SHALL go to reset values on the next edge, and a new operation SHALL complete correctly afterwards.
REQ-033 With SEQ_MULT_EARLY_TERM_EN defined, WIDTH=8 and op_b=0x01: DONE SHALL occur 1 edge after accept; with op_b=0x00: product SHALL be 0; and without the macro, the same op_b=0x01 case SHALL take 8 edges.
REQ-034 With WIDTH=16, 10000 random signed and unsigned operations: every product SHALL match a reference model, and in_ready and out_valid SHALL never both be 1.

Source files
------------

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult -- sequential shift-add multiplier (signed or unsigned operands)
//
// Accepts one operand pair per transaction through a valid/ready handshake,
// iterates one multiplier bit per clock and presents the 2*WIDTH-bit product
// through a second valid/ready handshake. Signed operands are multiplied as
// magnitudes; the sign is applied by negating the accumulator on the last
// iteration, so the product is already final on the first out_valid cycle.
//
// Parameters
//   WIDTH      operand width in bits (2..32)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands and mode presented
//   in_ready   block idle and able to accept operands
//   op_a       multiplicand, index 0 is the MSB
//   op_b       multiplier, index 0 is the MSB
//   is_signed  1: two's-complement operands, 0: unsigned
//   out_valid  product valid (held until out_ready)
//   out_ready  consumer accepts the product
//   product    2*WIDTH-bit result, index 0 is the MSB
//   busy       high whenever the FSM is not IDLE
//
// Configuration
//   SEQ_MULT_EARLY_TERM_EN  when defined, finish as soon as no 1 bits remain
//                           in the multiplier (latency 1..WIDTH edges);
//                           otherwise latency is always WIDTH edges.
// -----------------------------------------------------------------------------
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:WIDTH-1]   op_a,
   input  logic [0:WIDTH-1]   op_b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:2*WIDTH-1] product,
   output logic               busy
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic signed [PW-1:0]     acc_q;
   logic        [PW-1:0]     mcand_q;
   logic        [WIDTH-1:0]  mplier_q;
   logic        [CNT_W-1:0]  cnt_q;
   logic                     sign_q;

   logic        [WIDTH-1:0]  a_w;
   logic        [WIDTH-1:0]  b_w;
   logic        [WIDTH-1:0]  a_mag_d;
   logic        [WIDTH-1:0]  b_mag_d;
   logic                     sign_d;
   logic signed [PW-1:0]     sum_d;
   logic signed [PW-1:0]     acc_d;
   logic                     last_d;

   // Two's-complement negation over the full product width.
   function automatic logic signed [PW-1:0] neg2c(input logic signed [PW-1:0] v);
      return ~v + PW'(1);
   endfunction

   // Magnitude of a WIDTH-bit operand; the most negative value maps to
   // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   // Re-index the MSB-first ports into conventional descending vectors.
   assign a_w = op_a;
   assign b_w = op_b;

   // Capture-side operand conditioning.
   always_comb begin
      a_mag_d = mag(a_w, is_signed);
      b_mag_d = mag(b_w, is_signed);
      sign_d  = is_signed & (a_w[WIDTH-1] ^ b_w[WIDTH-1]);
   end

   // Iteration datapath: mcand_q is pre-shifted each step, so it always
   // equals the zero-extended multiplicand shifted by the iteration count.
   always_comb begin
      sum_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
      last_d = (mplier_q[WIDTH-1:1] == '0);
`else
      last_d = (cnt_q == CNT_W'(WIDTH - 1));
`endif
      acc_d = (last_d && sign_q) ? neg2c(sum_d) : sum_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q    <= {{WIDTH{1'b0}}, a_mag_d};
                  mplier_q   <= b_mag_d;
                  sign_q     <= sign_d;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_d) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               // in_ready stays low here, so no accept can share this edge.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = acc_q;

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

   localparam int W = 8;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           is_signed = 1'b0;
   logic           out_ready = 1'b1;
   logic [W-1:0]   op_a      = '0;
   logic [W-1:0]   op_b      = '0;
   logic           in_ready;
   logic           out_valid;
   logic           busy;
   logic [2*W-1:0] product;

   seq_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic [15:0] prod;
      int          acc_cyc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   bit          seen     = 1'b0;
   logic [15:0] held     = '0;
   bit          excl_bad = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
   endtask

   function automatic int exp_lat(input logic [7:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
      logic [7:0] m;
      int l;
      m = (s && b[7]) ? -b : b;
      l = 1;
      for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
      return l;
`else
      return W;
`endif
   endfunction

   // Monitor: pops the scoreboard on the first out_valid cycle of each
   // product, then checks the product holds until the handoff.
   always @(negedge clk) begin
      exp_t e;
      if (in_ready && out_valid) excl_bad = 1'b1;
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               e = sb.pop_front();
               chk("product", product, e.prod);
               chk("latency", cyc - e.acc_cyc, e.lat);
            end
            seen = 1'b1;
            held = product;
         end else begin
            chk("product_stable", product, held);
         end
         if (out_ready) seen = 1'b0;
      end
   end

   // Called at posedge+1; returns at the posedge+1 right after the accept edge.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] p);
      exp_t e;
      int   t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         fail_now("issue_wait_ready");
         return;
      end
      in_valid  = 1'b1;
      op_a      = a;
      op_b      = b;
      is_signed = s;
      e.prod    = p;
      e.acc_cyc = cyc + 1;
      e.lat     = exp_lat(b, s);
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      // Scramble the inputs: captured operands must not follow them.
      op_a      = ~a;
      op_b      = ~b;
      is_signed = ~s;
      chk("busy_after_accept", busy, 1);
      chk("in_ready_after_accept", in_ready, 0);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0 || !in_ready) fail_now("wait_done");
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[12] = '{
      '{8'hFF, 8'hFF, 1'b0, 16'hFE01},   // 255*255
      '{8'h80, 8'h80, 1'b1, 16'h4000},   // -128*-128
      '{8'hFF, 8'h7F, 1'b1, 16'hFF81},   // -1*127
      '{8'h00, 8'hAB, 1'b0, 16'h0000},   // 0*171
      '{8'h03, 8'h05, 1'b0, 16'h000F},   // 3*5
      '{8'h05, 8'hFD, 1'b1, 16'hFFF1},   // 5*-3
      '{8'h80, 8'h7F, 1'b1, 16'hC080},   // -128*127
      '{8'h80, 8'h02, 1'b0, 16'h0100},   // 128*2
      '{8'h12, 8'h01, 1'b0, 16'h0012},   // 18*1
      '{8'hFE, 8'h00, 1'b1, 16'h0000},   // -2*0
      '{8'hC8, 8'h64, 1'b0, 16'h4E20},   // 200*100
      '{8'h7F, 8'h7F, 1'b1, 16'h3F01}    // 127*127
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_product", product, 0);
      rst_n = 1'b1;

      // Directed vectors, back to back
      foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
      wait_done();

      // Consumer stall: out_ready low for 5 DONE cycles, in_valid ignored
      out_ready = 1'b0;
      issue(8'hC8, 8'h64, 1'b0, 16'h4E20);
      begin
         int t;
         t = 0;
         while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
         end
         if (!out_valid) fail_now("stall_wait_valid");
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         in_valid  = 1'b1;
         op_a      = 8'($urandom);
         op_b      = 8'($urandom);
         is_signed = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_in_ready", in_ready, 1);
      chk("stall_release_out_valid", out_valid, 0);
      chk("stall_release_busy", busy, 0);

      // Reset three cycles into BUSY aborts the operation
      issue(8'h37, 8'h11, 1'b0, 16'h03A7);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_product", product, 0);
      rst_n = 1'b1;
      // Accept on the first edge after reset release
      issue(8'h37, 8'h11, 1'b0, 16'h03A7);
      issue(8'hFB, 8'h06, 1'b1, 16'hFFE2);   // -5*6
      wait_done();

      chk("never_in_ready_and_out_valid", excl_bad, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
